// File: rtl/div_sched_pkg.sv
// Shared constants for the div_sched clock-divider controller.
// State encoding is kept as plain localparams so it stays legacy-tool friendly.
package div_sched_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_PEND = 2'd2;

    // Smallest divisor that produces a meaningful period.
    localparam int DIV_MIN = 1;

endpackage

// File: rtl/div_counter.sv
// Mod-N period counter.
// Holds the divisor in effect and reports the last cycle of a period and the high half.
module div_counter #(
    parameter int WIDTH = 8,
    parameter int DEF_N = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_div_i,
    output logic [WIDTH-1:0] div_o,
    output logic             wrap_o,
    output logic             half_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;

    // div_q is never zero, so div_q-1 cannot underflow.
    assign wrap_o = (cnt_q == (div_q - WIDTH'(1)));
    assign half_o = (cnt_q >= (div_q >> 1));
    assign div_o  = div_q;

    always_comb begin
        cnt_d = cnt_q + WIDTH'(1);
        if (clear_i || !run_i || wrap_o) begin
            cnt_d = '0;
        end
        div_d = load_i ? load_div_i : div_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            div_q <= WIDTH'(DEF_N);
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/div_sched.sv
// Runtime-reprogrammable clock divider: divisor updates over valid/ready are
// applied only at period boundaries, and start/stop also lands on boundaries.
module div_sched
    import div_sched_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEF_N = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic [WIDTH-1:0] cur_div,
    output logic             running,
    output logic             tick,
    output logic             sq,
    output logic [1:0]       dbg_state_o
);

    // Handshake: a transfer happens on any rising edge where cfg_valid and
    // cfg_ready are both high; cfg_div is only looked at on that edge, and
    // cfg_ready is low only while a divisor is already waiting (PEND).

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;
    logic             err_q, err_d;

    logic             xfer;
    logic             div_ok;
    logic             load;
    logic [WIDTH-1:0] load_div;
    logic             wrap;
    logic             half;

    assign running     = (state_q != ST_IDLE);
    assign cfg_ready   = (state_q != ST_PEND);
    assign xfer        = cfg_valid && cfg_ready;
    assign div_ok      = (cfg_div >= WIDTH'(DIV_MIN));
    assign dbg_state_o = state_q;

    div_counter #(
        .WIDTH (WIDTH),
        .DEF_N (DEF_N)
    ) u_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .run_i      (running),
        .clear_i    (load),
        .load_i     (load),
        .load_div_i (load_div),
        .div_o      (cur_div),
        .wrap_o     (wrap),
        .half_o     (half)
    );

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        load     = 1'b0;
        load_div = cfg_div;
        case (state_q)
            ST_IDLE: begin
                load = xfer && div_ok;
                if (enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (wrap) begin
                    // Update on the boundary itself skips the PEND detour.
                    load = xfer && div_ok;
                    if (!enable) begin
                        state_d = ST_IDLE;
                    end
                end else if (xfer && div_ok) begin
                    pend_d  = cfg_div;
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (wrap) begin
                    load     = 1'b1;
                    load_div = pend_q;
                    pend_d   = '0;
                    state_d  = enable ? ST_RUN : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        tick_d = running && wrap;
        sq_d   = running && half;
        err_d  = xfer && !div_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            tick_q  <= 1'b0;
            sq_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            tick_q  <= tick_d;
            sq_q    <= sq_d;
            err_q   <= err_d;
        end
    end

    assign tick    = tick_q;
    assign sq      = sq_q;
    assign cfg_err = err_q;

endmodule
